// File: rtl/serial_rx_package.sv
`default_nettype none
// ============================================================================
// Module      : serial_rx_package
// Description : Asynchronous serial receiver that assembles 2^AddressWidth
//               words into one package and publishes it with a valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_rx_package #(
   parameter int AddressWidth     = 2,
   parameter int WordWidth        = 8,
   parameter int SerialTimerWidth = 8,
   parameter int BitPeriod        = 16
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  rx,
   input  logic                                  ce,
   output logic [WordWidth*(2**AddressWidth)-1:0] data,
   output logic                                  valid,
   output logic                                  busy,
   output logic                                  frameError
);

   localparam int c_WORDS = 2 ** AddressWidth;
   localparam int c_PKG_W = WordWidth * c_WORDS;
   localparam int c_IDX_W = (AddressWidth > 0) ? AddressWidth : 1;
   localparam int c_CNT_W = $clog2(WordWidth + 1);

   localparam logic [SerialTimerWidth-1:0] c_HALF      = SerialTimerWidth'(BitPeriod / 2 - 1);
   localparam logic [SerialTimerWidth-1:0] c_FULL      = SerialTimerWidth'(BitPeriod - 1);
   localparam logic [SerialTimerWidth-1:0] c_TIMER_ONE = SerialTimerWidth'(1);
   localparam logic [c_CNT_W-1:0]          c_LAST_BIT  = c_CNT_W'(WordWidth - 1);
   localparam logic [c_CNT_W-1:0]          c_CNT_ONE   = c_CNT_W'(1);
   localparam logic [c_IDX_W-1:0]          c_LAST_IDX  = c_IDX_W'(c_WORDS - 1);
   localparam logic [c_IDX_W-1:0]          c_IDX_ONE   = c_IDX_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t                      r_state;
   state_t                      w_stateNext;
   logic                        r_sync1;
   logic                        r_rxs;
   logic                        r_rxp;
   logic [SerialTimerWidth-1:0] r_timer;
   logic [SerialTimerWidth-1:0] w_timerNext;
   logic [c_CNT_W-1:0]          r_bitCnt;
   logic [WordWidth-1:0]        r_shift;
   logic [c_IDX_W-1:0]          r_index;
   logic [c_PKG_W-1:0]          r_pkg;
   logic [c_PKG_W-1:0]          w_pkgNext;
   logic                        w_sampleBit;
   logic                        w_sampleStop;
   logic                        w_timerDone;

   assign w_timerDone = (r_timer == '0);
   assign busy        = (r_state != IDLE) || (r_index != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_timer <= '0;
      end else begin
         r_state <= w_stateNext;
         r_timer <= w_timerNext;
      end
   end

   // Timer counts down to zero and parks there; every transition reloads it.
   always_comb begin
      w_stateNext  = r_state;
      w_timerNext  = w_timerDone ? '0 : (r_timer - c_TIMER_ONE);
      w_sampleBit  = 1'b0;
      w_sampleStop = 1'b0;
      case (r_state)
         IDLE: begin
            if (ce && r_rxp && !r_rxs) begin
               w_stateNext = START;
               w_timerNext = c_HALF;
            end
         end
         START: begin
            if (w_timerDone) begin
               if (r_rxs) begin
                  w_stateNext = IDLE;
                  w_timerNext = '0;
               end else begin
                  w_stateNext = DATA;
                  w_timerNext = c_FULL;
               end
            end
         end
         DATA: begin
            if (w_timerDone) begin
               w_sampleBit = 1'b1;
               w_timerNext = c_FULL;
               if (r_bitCnt == c_LAST_BIT) begin
                  w_stateNext = STOP;
               end
            end
         end
         STOP: begin
            if (w_timerDone) begin
               w_sampleStop = 1'b1;
               w_stateNext  = IDLE;
               w_timerNext  = '0;
            end
         end
         default: begin
            w_stateNext = IDLE;
            w_timerNext = '0;
         end
      endcase
   end

   // First word lands in the most significant slot, last word in the least.
   always_comb begin
      w_pkgNext = r_pkg;
      w_pkgNext[(c_WORDS - 1 - int'(r_index)) * WordWidth +: WordWidth] = r_shift;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1    <= 1'b1;
         r_rxs      <= 1'b1;
         r_rxp      <= 1'b1;
         r_bitCnt   <= '0;
         r_shift    <= '0;
         r_index    <= '0;
         r_pkg      <= '0;
         data       <= '0;
         valid      <= 1'b0;
         frameError <= 1'b0;
      end else begin
         r_sync1 <= rx;
         r_rxs   <= r_sync1;
         r_rxp   <= r_rxs;
         valid   <= 1'b0;
         if (w_sampleBit) begin
            r_shift  <= WordWidth'({r_rxs, r_shift} >> 1);
            r_bitCnt <= (r_bitCnt == c_LAST_BIT) ? '0 : (r_bitCnt + c_CNT_ONE);
         end
         if (w_sampleStop) begin
            if (r_rxs) begin
               r_pkg <= w_pkgNext;
               if (r_index == c_LAST_IDX) begin
                  r_index    <= '0;
                  data       <= w_pkgNext;
                  valid      <= 1'b1;
                  frameError <= 1'b0;
               end else begin
                  r_index <= r_index + c_IDX_ONE;
               end
            end else begin
               r_index    <= '0;
               frameError <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_rx_package.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_rx_package
// Description : Directed self-checking bench for serial_rx_package (defaults).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_rx_package;

   logic        clk;
   logic        rst;
   logic        rx;
   logic        ce;
   logic [31:0] data;
   logic        valid;
   logic        busy;
   logic        frameError;

   int checks;
   int failures;
   int validTotal;
   int vo;
   int vc;
   int vSum;
   int vBefore;

   serial_rx_package #(
      .AddressWidth(2),
      .WordWidth(8),
      .SerialTimerWidth(8),
      .BitPeriod(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rx(rx),
      .ce(ce),
      .data(data),
      .valid(valid),
      .busy(busy),
      .frameError(frameError)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (valid === 1'b1) validTotal++;
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drives one frame starting at a negedge; offsets count negedges from the start edge.
   task automatic sendByte(input logic [7:0] b, input logic stopBit, input int nCycles,
                           input int ceDropAt, output int vOff, output int vCnt);
      logic [9:0] frame;
      frame = {stopBit, b, 1'b0};
      vOff  = -1;
      vCnt  = 0;
      for (int k = 0; k < nCycles; k++) begin
         rx = frame[k / 16];
         if (k == ceDropAt) ce = 1'b0;
         @(negedge clk);
         if (valid === 1'b1) begin
            vCnt++;
            if (vOff < 0) vOff = k + 1;
         end
      end
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      validTotal = 0;
      rst = 1'b1;
      rx  = 1'b1;
      ce  = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_data", data, 32'h0);
      check("reset_valid", {31'd0, valid}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_frameError", {31'd0, frameError}, 32'd0);
      rst = 1'b0;
      idle(5);

      // Basic package and valid timing
      vSum = 0;
      sendByte(8'h00, 1'b1, 160, -1, vo, vc); vSum += vc;
      check("pkg1_busy_partial", {31'd0, busy}, 32'd1);
      sendByte(8'h30, 1'b1, 160, -1, vo, vc); vSum += vc;
      sendByte(8'h18, 1'b1, 160, -1, vo, vc); vSum += vc;
      check("pkg1_no_early_valid", vSum, 32'd0);
      sendByte(8'h00, 1'b1, 160, -1, vo, vc);
      check("pkg1_valid_offset", vo, 32'd155);
      check("pkg1_valid_count", vc, 32'd1);
      check("pkg1_data", data, 32'h00301800);
      check("pkg1_busy_after", {31'd0, busy}, 32'd0);

      // Bit order: 0xA5 first word lands in the top byte
      sendByte(8'hA5, 1'b1, 160, -1, vo, vc);
      sendByte(8'h5A, 1'b1, 160, -1, vo, vc);
      sendByte(8'hC3, 1'b1, 160, -1, vo, vc);
      check("pkg2_data_held", data, 32'h00301800);
      sendByte(8'h3C, 1'b1, 160, -1, vo, vc);
      check("pkg2_data", data, 32'hA55AC33C);

      // Short low glitch on an idle line
      vBefore = validTotal;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      @(negedge clk);
      check("glitch_busy_mid", {31'd0, busy}, 32'd1);
      idle(20);
      check("glitch_busy_after", {31'd0, busy}, 32'd0);
      check("glitch_no_valid", validTotal - vBefore, 32'd0);
      check("glitch_data", data, 32'hA55AC33C);

      // Frame error on the second byte, then recovery
      sendByte(8'h01, 1'b1, 160, -1, vo, vc);
      sendByte(8'h02, 1'b0, 160, -1, vo, vc);
      check("ferr_set", {31'd0, frameError}, 32'd1);
      check("ferr_index_cleared", {31'd0, busy}, 32'd0);
      check("ferr_data", data, 32'hA55AC33C);
      check("ferr_no_valid", vc, 32'd0);
      idle(20);
      sendByte(8'h11, 1'b1, 160, -1, vo, vc);
      sendByte(8'h22, 1'b1, 160, -1, vo, vc);
      sendByte(8'h33, 1'b1, 160, -1, vo, vc);
      check("ferr_sticky", {31'd0, frameError}, 32'd1);
      sendByte(8'h44, 1'b1, 160, -1, vo, vc);
      check("ferr_valid_offset", vo, 32'd155);
      check("ferr_cleared", {31'd0, frameError}, 32'd0);
      check("ferr_recover_data", data, 32'h11223344);

      // Reset in the middle of the third byte
      sendByte(8'hDE, 1'b1, 160, -1, vo, vc);
      sendByte(8'hAD, 1'b1, 160, -1, vo, vc);
      sendByte(8'hBE, 1'b1, 50, -1, vo, vc);
      check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      rx  = 1'b1;
      @(negedge clk);
      check("rst_mid_data", data, 32'h0);
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_valid", {31'd0, valid}, 32'd0);
      check("rst_mid_frameError", {31'd0, frameError}, 32'd0);
      rst = 1'b0;
      idle(20);
      sendByte(8'h12, 1'b1, 160, -1, vo, vc);
      sendByte(8'h34, 1'b1, 160, -1, vo, vc);
      sendByte(8'h56, 1'b1, 160, -1, vo, vc);
      sendByte(8'h78, 1'b1, 160, -1, vo, vc);
      check("rst_recover_valid", vc, 32'd1);
      check("rst_recover_data", data, 32'h12345678);

      // Receive enable behaviour
      vBefore = validTotal;
      ce = 1'b0;
      sendByte(8'h77, 1'b1, 160, -1, vo, vc);
      check("ce_off_busy", {31'd0, busy}, 32'd0);
      check("ce_off_no_valid", validTotal - vBefore, 32'd0);
      ce = 1'b1;
      sendByte(8'h9C, 1'b1, 160, 40, vo, vc);
      check("ce_drop_stored", {31'd0, busy}, 32'd1);
      idle(30);
      check("ce_drop_retained", {31'd0, busy}, 32'd1);
      ce = 1'b1;
      sendByte(8'hAB, 1'b1, 160, -1, vo, vc);
      sendByte(8'hCD, 1'b1, 160, -1, vo, vc);
      sendByte(8'hEF, 1'b1, 160, -1, vo, vc);
      check("ce_pkg_valid", vc, 32'd1);
      check("ce_pkg_data", data, 32'h9CABCDEF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
